// File: rtl/gpr_writeback_arb_pkg.sv
// Shared register-id encoding and writeback payload types for the GPR writeback arbiter.
package gpr_writeback_arb_pkg;

  localparam int unsigned REG_ID_W = 7;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned GPR_CNT  = 16;

  typedef logic [REG_ID_W-1:0] uregId_t;

  localparam uregId_t UREG_R0  = 7'h00;
  localparam uregId_t UREG_R15 = 7'h0F;
  localparam uregId_t UREG_SR  = 7'h20;
  localparam uregId_t UREG_GBR = 7'h21;
  localparam uregId_t UREG_ZZR = 7'h7F;

  typedef struct packed {
    uregId_t           id;
    logic [DATA_W-1:0] val;
  } wbEntry_t;

  // R0..R15 occupy ids 0x00..0x0F; everything else is a special register
  function automatic logic isGpr(input uregId_t id);
    return id[REG_ID_W-1:4] == 3'b000;
  endfunction

  function automatic logic pendHit(input logic [GPR_CNT-1:0] sb, input uregId_t id);
    return isGpr(id) && sb[id[3:0]];
  endfunction

endpackage

// File: rtl/gpr_writeback_arb_if.sv
// Upstream/bank-side signal bundle of the GPR writeback arbiter.
interface gpr_writeback_arb_if;
  import gpr_writeback_arb_pkg::*;

  logic              exValid;
  uregId_t           exIdRn;
  logic [DATA_W-1:0] exValRn;
  logic              ldIssue;
  uregId_t           ldIdRn;
  logic              memValid;
  uregId_t           memIdRn;
  logic [DATA_W-1:0] memVal;
  uregId_t           qIdRs, qIdRt, qIdRn;
  logic [DATA_W-1:0] rawRs, rawRt, rawRn;
  logic [DATA_W-1:0] fwdRs, fwdRt, fwdRn;
  uregId_t           regIdRo;
  logic [DATA_W-1:0] regValRo;
  logic              wbHold;
  logic              wbErr;

  modport master (
    output exValid, exIdRn, exValRn, ldIssue, ldIdRn,
    output memValid, memIdRn, memVal,
    output qIdRs, qIdRt, qIdRn, rawRs, rawRt, rawRn,
    input  fwdRs, fwdRt, fwdRn, regIdRo, regValRo, wbHold, wbErr
  );

  modport slave (
    input  exValid, exIdRn, exValRn, ldIssue, ldIdRn,
    input  memValid, memIdRn, memVal,
    input  qIdRs, qIdRt, qIdRn, rawRs, rawRt, rawRn,
    output fwdRs, fwdRt, fwdRn, regIdRo, regValRo, wbHold, wbErr
  );
endinterface

// File: rtl/wb_fifo2.sv
// Two-entry FIFO buffering load returns that lose writeback arbitration.
module wb_fifo2
  import gpr_writeback_arb_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  wbEntry_t pushData,
  output wbEntry_t head,
  output logic [1:0] count
);

  wbEntry_t mem [2];
  logic     rdPtr;
  logic     wrPtr;
  logic     doPush;
  logic     doPop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle
  assign doPop  = pop && (count != 2'd0);
  assign doPush = push && ((count != 2'd2) || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rdPtr <= 1'b0;
      wrPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) rdPtr <= ~rdPtr;
      count <= count + 2'(doPush) - 2'(doPop);
    end
  end

endmodule

// File: rtl/gpr_writeback_arb.sv
// GPR write-port arbiter: merges EX results with load returns, tracks pending
// loads, requests pipeline hold on hazards and forwards the presented write.
module gpr_writeback_arb
  import gpr_writeback_arb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic clock,
  input logic reset,
  gpr_writeback_arb_if.slave wb
);

  logic [GPR_CNT-1:0] pend;
  logic [GPR_CNT-1:0] pendNext;
  logic               roLoad;
  uregId_t            regIdQ;
  logic [DATA_W-1:0]  regValQ;
  logic               errQ;

  wbEntry_t   fifoHead;
  wbEntry_t   memEntry;
  wbEntry_t   selEntry;
  logic [1:0] fifoCount;
  logic       fifoPush;
  logic       fifoPop;
  logic       selValid;
  logic       selLoad;
  logic       hold;
  logic       exAcc;
  logic       ldAcc;

  assign memEntry = '{id: wb.memIdRn, val: wb.memVal};

  // Hazard hold: full buffer, RAW on any ID read, WAW from EX or a repeated load
  always_comb begin
    hold = (fifoCount == 2'(FIFO_DEPTH))
        || pendHit(pend, wb.qIdRs) || pendHit(pend, wb.qIdRt) || pendHit(pend, wb.qIdRn)
        || (wb.exValid && pendHit(pend, wb.exIdRn))
        || (wb.ldIssue && pendHit(pend, wb.ldIdRn));
  end

  assign exAcc = wb.exValid && !hold;
  assign ldAcc = wb.ldIssue && !hold;

  // Priority: accepted EX, then FIFO head, then a direct load return
  always_comb begin
    selValid = 1'b0;
    selLoad  = 1'b0;
    selEntry = '0;
    fifoPop  = 1'b0;
    fifoPush = 1'b0;
    if (exAcc) begin
      selValid = 1'b1;
      selEntry = '{id: wb.exIdRn, val: wb.exValRn};
      fifoPush = wb.memValid;
    end else if (fifoCount != 2'd0) begin
      selValid = 1'b1;
      selLoad  = 1'b1;
      selEntry = fifoHead;
      fifoPop  = 1'b1;
      fifoPush = wb.memValid;
    end else if (wb.memValid) begin
      selValid = 1'b1;
      selLoad  = 1'b1;
      selEntry = memEntry;
    end
  end

  wb_fifo2 uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifoPush),
    .pop      (fifoPop),
    .pushData (memEntry),
    .head     (fifoHead),
    .count    (fifoCount)
  );

  // Set is applied after clear so a same-edge reissue keeps the bit pending
  always_comb begin
    pendNext = pend;
    if (roLoad && isGpr(regIdQ)) pendNext[regIdQ[3:0]] = 1'b0;
    if (ldAcc && isGpr(wb.ldIdRn)) pendNext[wb.ldIdRn[3:0]] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend    <= '0;
      roLoad  <= 1'b0;
      regIdQ  <= UREG_ZZR;
      regValQ <= '0;
      errQ    <= 1'b0;
    end else begin
      pend <= pendNext;
      if (wb.memValid && !pendHit(pend, wb.memIdRn)) errQ <= 1'b1;
      if (selValid) begin
        regIdQ  <= selEntry.id;
        regValQ <= selEntry.val;
        roLoad  <= selLoad;
      end else begin
        regIdQ  <= UREG_ZZR;
        roLoad  <= 1'b0;
      end
    end
  end

  assign wb.regIdRo  = regIdQ;
  assign wb.regValRo = regValQ;
  assign wb.wbErr    = errQ;
  assign wb.wbHold   = hold;

  // Same-cycle read of the register being written sees the new value
  assign wb.fwdRs = (wb.qIdRs == regIdQ && regIdQ != UREG_ZZR) ? regValQ : wb.rawRs;
  assign wb.fwdRt = (wb.qIdRt == regIdQ && regIdQ != UREG_ZZR) ? regValQ : wb.rawRt;
  assign wb.fwdRn = (wb.qIdRn == regIdQ && regIdQ != UREG_ZZR) ? regValQ : wb.rawRn;

endmodule

// File: tb/tb_gpr_writeback_arb.sv
// Directed, table-driven bench for gpr_writeback_arb with hand-written
// sequences for FIFO saturation, special-register forwarding and mid-run reset.
module tb_gpr_writeback_arb;
  import gpr_writeback_arb_pkg::*;

  localparam logic [31:0] RAW_DFLT = 32'hF0F0_F0F0;
  localparam logic [31:0] RAW_RT   = 32'h5555_0000;
  localparam logic [31:0] RAW_RN   = 32'h6666_0000;

  typedef struct {
    string       name;
    logic        exV;
    uregId_t     exId;
    logic [31:0] exVal;
    logic        ldI;
    uregId_t     ldId;
    logic        memV;
    uregId_t     memId;
    logic [31:0] memVal;
    uregId_t     qRs;
    logic [31:0] rawRs;
    uregId_t     eId;
    logic [31:0] eVal;
    logic        eHold;
    logic [31:0] eFwd;
    logic        eErr;
  } vec_t;

  logic clock;
  logic reset;
  int   nTests;
  int   nFail;
  vec_t tbl[$];

  gpr_writeback_arb_if wbIf ();

  gpr_writeback_arb #(.FIFO_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wbIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input string name,
                              input logic exV, input uregId_t exId, input logic [31:0] exVal,
                              input logic ldI, input uregId_t ldId,
                              input logic memV, input uregId_t memId, input logic [31:0] memVal,
                              input uregId_t qRs, input logic [31:0] rawRs,
                              input uregId_t eId, input logic [31:0] eVal, input logic eHold,
                              input logic [31:0] eFwd, input logic eErr);
    vec_t v;
    v.name = name; v.exV = exV; v.exId = exId; v.exVal = exVal;
    v.ldI = ldI; v.ldId = ldId; v.memV = memV; v.memId = memId; v.memVal = memVal;
    v.qRs = qRs; v.rawRs = rawRs;
    v.eId = eId; v.eVal = eVal; v.eHold = eHold; v.eFwd = eFwd; v.eErr = eErr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic setIdle();
    wbIf.exValid  = 1'b0; wbIf.exIdRn  = UREG_R0; wbIf.exValRn = '0;
    wbIf.ldIssue  = 1'b0; wbIf.ldIdRn  = UREG_R0;
    wbIf.memValid = 1'b0; wbIf.memIdRn = UREG_R0; wbIf.memVal  = '0;
    wbIf.qIdRs = UREG_R15; wbIf.rawRs = RAW_DFLT;
    wbIf.qIdRt = UREG_SR;  wbIf.rawRt = RAW_RT;
    wbIf.qIdRn = UREG_GBR; wbIf.rawRn = RAW_RN;
  endtask

  task automatic chkOut(input string nm, input uregId_t eId, input logic [31:0] eVal,
                        input logic eHold, input logic [31:0] eFwd, input logic eErr);
    chk($sformatf("%s.regIdRo", nm),  32'(wbIf.regIdRo), 32'(eId));
    chk($sformatf("%s.regValRo", nm), wbIf.regValRo, eVal);
    chk($sformatf("%s.wbHold", nm),   32'(wbIf.wbHold), 32'(eHold));
    chk($sformatf("%s.fwdRs", nm),    wbIf.fwdRs, eFwd);
    chk($sformatf("%s.wbErr", nm),    32'(wbIf.wbErr), 32'(eErr));
  endtask

  // Drive one cycle of stimulus in the low phase, check, then advance a cycle
  task automatic applyVec(input vec_t v);
    setIdle();
    wbIf.exValid  = v.exV;  wbIf.exIdRn  = v.exId;  wbIf.exValRn = v.exVal;
    wbIf.ldIssue  = v.ldI;  wbIf.ldIdRn  = v.ldId;
    wbIf.memValid = v.memV; wbIf.memIdRn = v.memId; wbIf.memVal  = v.memVal;
    wbIf.qIdRs    = v.qRs;  wbIf.rawRs   = v.rawRs;
    #1;
    chkOut(v.name, v.eId, v.eVal, v.eHold, v.eFwd, v.eErr);
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    nTests = 0;
    nFail  = 0;

    // EX write, load RAW hold/forward, EX/load collision, WAW
    tbl.push_back(mk("c0_idle",     0,7'd0,0,           0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,0,0,RAW_DFLT,0));
    tbl.push_back(mk("c1_exR3",     1,7'd3,32'h11223344,0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,0,0,RAW_DFLT,0));
    tbl.push_back(mk("c2_presR3",   0,7'd0,0,           0,7'd0, 0,7'd0,0,              7'd3,0,            7'd3,32'h11223344,0,32'h11223344,0));
    tbl.push_back(mk("c3_done",     0,7'd0,0,           0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'h11223344,0,RAW_DFLT,0));
    tbl.push_back(mk("c4_ldR5",     0,7'd0,0,           1,7'd5, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'h11223344,0,RAW_DFLT,0));
    tbl.push_back(mk("c5_rawHold",  0,7'd0,0,           0,7'd0, 0,7'd0,0,              7'd5,0,            UREG_ZZR,32'h11223344,1,0,0));
    tbl.push_back(mk("c6_memR5",    0,7'd0,0,           0,7'd0, 1,7'd5,32'hCAFEF00D,   7'd5,0,            UREG_ZZR,32'h11223344,1,0,0));
    tbl.push_back(mk("c7_presR5",   0,7'd0,0,           0,7'd0, 0,7'd0,0,              7'd5,0,            7'd5,32'hCAFEF00D,1,32'hCAFEF00D,0));
    tbl.push_back(mk("c8_release",  0,7'd0,0,           0,7'd0, 0,7'd0,0,              7'd5,32'hCAFEF00D, UREG_ZZR,32'hCAFEF00D,0,32'hCAFEF00D,0));
    tbl.push_back(mk("c9_ldR2",     0,7'd0,0,           1,7'd2, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'hCAFEF00D,0,RAW_DFLT,0));
    tbl.push_back(mk("c10_collide", 1,7'd1,32'hA,       0,7'd0, 1,7'd2,32'hB,          UREG_R15,RAW_DFLT, UREG_ZZR,32'hCAFEF00D,0,RAW_DFLT,0));
    tbl.push_back(mk("c11_presR1",  0,7'd0,0,           0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, 7'd1,32'hA,0,RAW_DFLT,0));
    tbl.push_back(mk("c12_presR2",  0,7'd0,0,           0,7'd0, 0,7'd0,0,              7'd2,0,            7'd2,32'hB,1,32'hB,0));
    tbl.push_back(mk("c13_idle",    0,7'd0,0,           0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'hB,0,RAW_DFLT,0));
    tbl.push_back(mk("c14_ldR7",    0,7'd0,0,           1,7'd7, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'hB,0,RAW_DFLT,0));
    tbl.push_back(mk("c15_waw",     1,7'd7,32'h77,      0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'hB,1,RAW_DFLT,0));
    tbl.push_back(mk("c16_wawMem",  1,7'd7,32'h77,      0,7'd0, 1,7'd7,32'h700,        UREG_R15,RAW_DFLT, UREG_ZZR,32'hB,1,RAW_DFLT,0));
    tbl.push_back(mk("c17_presLd7", 1,7'd7,32'h77,      0,7'd0, 0,7'd0,0,              7'd7,0,            7'd7,32'h700,1,32'h700,0));
    tbl.push_back(mk("c18_exAcc7",  1,7'd7,32'h77,      0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, UREG_ZZR,32'h700,0,RAW_DFLT,0));
    tbl.push_back(mk("c19_presEx7", 0,7'd0,0,           0,7'd0, 0,7'd0,0,              UREG_R15,RAW_DFLT, 7'd7,32'h77,0,RAW_DFLT,0));

    setIdle();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    chkOut("reset", UREG_ZZR, 32'h0, 1'b0, RAW_DFLT, 1'b0);
    chk("reset.fwdRt", wbIf.fwdRt, RAW_RT);
    reset = 1'b1;

    foreach (tbl[i]) applyVec(tbl[i]);

    // Three load returns colliding with EX: FIFO fills, EX is held, order kept
    applyVec(mk("f0_ldR4",   0,7'd0,0,        1,7'd4, 0,7'd0,0,        UREG_R15,RAW_DFLT, UREG_ZZR,32'h77,0,RAW_DFLT,0));
    applyVec(mk("f1_ldR6",   0,7'd0,0,        1,7'd6, 0,7'd0,0,        UREG_R15,RAW_DFLT, UREG_ZZR,32'h77,0,RAW_DFLT,0));
    applyVec(mk("f2_ldR8",   0,7'd0,0,        1,7'd8, 0,7'd0,0,        UREG_R15,RAW_DFLT, UREG_ZZR,32'h77,0,RAW_DFLT,0));
    applyVec(mk("f3_col4",   1,7'd10,32'hA10, 0,7'd0, 1,7'd4,32'h400,  UREG_R15,RAW_DFLT, UREG_ZZR,32'h77,0,RAW_DFLT,0));
    applyVec(mk("f4_col6",   1,7'd11,32'hA11, 0,7'd0, 1,7'd6,32'h600,  UREG_R15,RAW_DFLT, 7'd10,32'hA10,0,RAW_DFLT,0));
    applyVec(mk("f5_full",   1,7'd12,32'hA12, 0,7'd0, 1,7'd8,32'h800,  UREG_R15,RAW_DFLT, 7'd11,32'hA11,1,RAW_DFLT,0));
    applyVec(mk("f6_full",   1,7'd12,32'hA12, 0,7'd0, 0,7'd0,0,        UREG_R15,RAW_DFLT, 7'd4,32'h400,1,RAW_DFLT,0));
    applyVec(mk("f7_exAcc",  1,7'd12,32'hA12, 0,7'd0, 0,7'd0,0,        UREG_R15,RAW_DFLT, 7'd6,32'h600,0,RAW_DFLT,0));
    applyVec(mk("f8_drain",  0,7'd0,0,        0,7'd0, 0,7'd0,0,        UREG_R15,RAW_DFLT, 7'd12,32'hA12,0,RAW_DFLT,0));
    applyVec(mk("f9_presR8", 0,7'd0,0,        0,7'd0, 0,7'd0,0,        UREG_R15,RAW_DFLT, 7'd8,32'h800,0,RAW_DFLT,0));
    applyVec(mk("f10_empty", 0,7'd0,0,        0,7'd0, 0,7'd0,0,        UREG_R15,RAW_DFLT, UREG_ZZR,32'h800,0,RAW_DFLT,0));

    // Special register: forwarded like a GPR, never scoreboarded
    applyVec(mk("g0_exSR",   1,UREG_SR,32'h5A5A5A5A, 0,7'd0, 0,7'd0,0, UREG_R15,RAW_DFLT, UREG_ZZR,32'h800,0,RAW_DFLT,0));
    setIdle();
    #1;
    chk("g1.regIdRo", 32'(wbIf.regIdRo), 32'(UREG_SR));
    chk("g1.fwdRt",   wbIf.fwdRt, 32'h5A5A5A5A);
    chk("g1.fwdRn",   wbIf.fwdRn, RAW_RN);
    chk("g1.wbHold",  32'(wbIf.wbHold), 32'd0);
    @(posedge clock);
    @(negedge clock);

    // Unexpected load return sets sticky error but still writes
    applyVec(mk("e0_memR9",  0,7'd0,0,  0,7'd0,  1,7'd9,32'h99,  UREG_R15,RAW_DFLT, UREG_ZZR,32'h5A5A5A5A,0,RAW_DFLT,0));
    applyVec(mk("e1_presR9", 0,7'd0,0,  0,7'd0,  0,7'd0,0,       UREG_R15,RAW_DFLT, 7'd9,32'h99,0,RAW_DFLT,1));
    applyVec(mk("e2_ldR13",  0,7'd0,0,  1,7'd13, 0,7'd0,0,       UREG_R15,RAW_DFLT, UREG_ZZR,32'h99,0,RAW_DFLT,1));
    applyVec(mk("e3_ldR14",  0,7'd0,0,  1,7'd14, 0,7'd0,0,       UREG_R15,RAW_DFLT, UREG_ZZR,32'h99,0,RAW_DFLT,1));
    applyVec(mk("e4_col13",  1,7'd1,32'h1, 0,7'd0, 1,7'd13,32'hD, UREG_R15,RAW_DFLT, UREG_ZZR,32'h99,0,RAW_DFLT,1));
    applyVec(mk("e5_col14",  1,7'd2,32'h2, 0,7'd0, 1,7'd14,32'hE, UREG_R15,RAW_DFLT, 7'd1,32'h1,0,RAW_DFLT,1));

    // Two entries queued: assert reset asynchronously in the low phase
    setIdle();
    #1;
    chkOut("e6_queued", 7'd2, 32'h2, 1'b1, RAW_DFLT, 1'b1);
    reset = 1'b0;
    #1;
    chkOut("e6_inReset", UREG_ZZR, 32'h0, 1'b0, RAW_DFLT, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    applyVec(mk("r0_after",  0,7'd0,0, 0,7'd0, 0,7'd0,0, UREG_R15,RAW_DFLT, UREG_ZZR,0,0,RAW_DFLT,0));
    applyVec(mk("r1_after",  0,7'd0,0, 0,7'd0, 0,7'd0,0, UREG_R15,RAW_DFLT, UREG_ZZR,0,0,RAW_DFLT,0));
    applyVec(mk("r2_noPend", 0,7'd0,0, 0,7'd0, 0,7'd0,0, 7'd13,32'h13,     UREG_ZZR,0,0,32'h13,0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
